// File: rtl/tluh_mem_responder_if.sv
// TL-UH 32-bit type definitions and the bundled TL + memory-port interface
// shared by the responder and its host/memory environment.
package tluh_32_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AUW = 16;
  localparam int TL_DUW = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

interface tluh_mem_responder_if;
  import tluh_32_pkg::*;

  tl_h2d_t          tl_i;
  tl_d2h_t          tl_o;
  logic             req_o;
  logic             gnt_i;
  logic             we_o;
  logic [TL_AW-1:0] addr_o;
  logic [TL_DW-1:0] wdata_o;
  logic [TL_DW-1:0] wmask_o;
  logic             rvalid_i;
  logic [TL_DW-1:0] rdata_i;
  logic             rerror_i;

  modport slave (
    input  tl_i, gnt_i, rvalid_i, rdata_i, rerror_i,
    output tl_o, req_o, we_o, addr_o, wdata_o, wmask_o
  );

  modport master (
    output tl_i, gnt_i, rvalid_i, rdata_i, rerror_i,
    input  tl_o, req_o, we_o, addr_o, wdata_o, wmask_o
  );
endinterface

// File: rtl/tluh_mem_responder.sv
// TL-UH device responder in front of a req/gnt/rvalid memory port: screens
// illegal requests locally and answers up to Outstanding requests in order.
module tluh_mem_responder
  import tluh_32_pkg::*;
#(
  parameter int Outstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tluh_mem_responder_if.slave  bus
);

  localparam int PW  = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(Outstanding + 1);
  localparam logic [CW-1:0]  DEPTH = CW'(Outstanding);
  localparam logic [PW-1:0]  LAST  = PW'(Outstanding - 1);
  localparam logic [PW1-1:0] WRAP  = PW1'(Outstanding);

  logic [TL_AIW-1:0] src_q   [Outstanding];
  logic [TL_SZW-1:0] size_q  [Outstanding];
  logic              get_q   [Outstanding];
  logic              err_q   [Outstanding];
  logic              pend_q  [Outstanding];
  logic              rerr_q  [Outstanding];
  logic [TL_DW-1:0]  data_q  [Outstanding];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [TL_DBW-1:0] smask;
  logic              misalign;
  logic              op_ok;
  logic              a_err;
  logic              full;
  logic              req;
  logic              a_ready;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic              mem_hit;
  logic [PW-1:0]     mem_idx;
  logic [PW1-1:0]    scan_sum;
  logic              complete;

  logic unused_a_user;
  assign unused_a_user = ^bus.tl_i.a_user;

  always_comb begin
    unique case (bus.tl_i.a_size)
      2'd0:    smask = 4'b0001;
      2'd1:    smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
    smask = smask << bus.tl_i.a_address[1:0];
  end

  always_comb begin
    unique case (bus.tl_i.a_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = bus.tl_i.a_address[0];
      default: misalign = |bus.tl_i.a_address[1:0];
    endcase
  end

  assign op_ok = (bus.tl_i.a_opcode == PutFullData) ||
                 (bus.tl_i.a_opcode == PutPartialData) ||
                 (bus.tl_i.a_opcode == Get);

  assign a_err = !op_ok || (bus.tl_i.a_param != 3'd0) || (bus.tl_i.a_size > 2'd2) ||
                 misalign || ((bus.tl_i.a_mask & ~smask) != '0) ||
                 ((bus.tl_i.a_opcode == PutFullData) && (bus.tl_i.a_mask != smask));

  // Illegal requests bypass memory, so they only need FIFO room to be accepted.
  assign full    = (count_q == DEPTH);
  assign req     = bus.tl_i.a_valid && !full && !a_err && !rst_i;
  assign a_ready = !rst_i && (a_err ? !full : (req && bus.gnt_i));
  assign push    = bus.tl_i.a_valid && a_ready;

  assign bus.req_o   = req;
  assign bus.we_o    = (bus.tl_i.a_opcode == PutFullData) ||
                       (bus.tl_i.a_opcode == PutPartialData);
  assign bus.addr_o  = {bus.tl_i.a_address[TL_AW-1:2], 2'b00};
  assign bus.wdata_o = bus.tl_i.a_data;
  assign bus.wmask_o = {{8{bus.tl_i.a_mask[3]}}, {8{bus.tl_i.a_mask[2]}},
                        {8{bus.tl_i.a_mask[1]}}, {8{bus.tl_i.a_mask[0]}}};

  // Memory responses are in order, so each one belongs to the oldest pending entry.
  always_comb begin
    mem_hit  = 1'b0;
    mem_idx  = '0;
    scan_sum = '0;
    for (int i = 0; i < Outstanding; i++) begin
      scan_sum = {1'b0, rd_ptr_q} + PW1'(i);
      if (scan_sum >= WRAP) scan_sum = scan_sum - WRAP;
      if (!mem_hit && (CW'(i) < count_q) && pend_q[scan_sum[PW-1:0]]) begin
        mem_hit = 1'b1;
        mem_idx = scan_sum[PW-1:0];
      end
    end
  end

  assign complete   = bus.rvalid_i && mem_hit && !rst_i;
  assign head_valid = (count_q != '0) && !pend_q[rd_ptr_q] && !rst_i;
  assign pop        = head_valid && bus.tl_i.d_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Outstanding; i++) begin
        pend_q[i] <= 1'b0;
        err_q[i]  <= 1'b0;
        rerr_q[i] <= 1'b0;
        get_q[i]  <= 1'b0;
        src_q[i]  <= '0;
        size_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        src_q[wr_ptr_q]  <= bus.tl_i.a_source;
        size_q[wr_ptr_q] <= bus.tl_i.a_size;
        get_q[wr_ptr_q]  <= (bus.tl_i.a_opcode == Get);
        err_q[wr_ptr_q]  <= a_err;
        pend_q[wr_ptr_q] <= !a_err;
        rerr_q[wr_ptr_q] <= 1'b0;
        data_q[wr_ptr_q] <= '0;
      end
      if (complete) begin
        data_q[mem_idx] <= get_q[mem_idx] ? bus.rdata_i : '0;
        rerr_q[mem_idx] <= rerr_q[mem_idx] | bus.rerror_i;
        pend_q[mem_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.tl_o          = '0;
    bus.tl_o.d_valid  = head_valid;
    bus.tl_o.d_opcode = get_q[rd_ptr_q] ? AccessAckData : AccessAck;
    bus.tl_o.d_size   = size_q[rd_ptr_q];
    bus.tl_o.d_source = src_q[rd_ptr_q];
    bus.tl_o.d_data   = err_q[rd_ptr_q] ? '0 : data_q[rd_ptr_q];
    bus.tl_o.d_error  = err_q[rd_ptr_q] | rerr_q[rd_ptr_q];
    bus.tl_o.a_ready  = a_ready;
  end

  logic [TL_AW+TL_DW+TL_AIW+TL_DBW+10:0] a_fields;
  assign a_fields = {bus.tl_i.a_opcode, bus.tl_i.a_param, bus.tl_i.a_size,
                     bus.tl_i.a_source, bus.tl_i.a_address, bus.tl_i.a_mask,
                     bus.tl_i.a_data};

  a_stable_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.tl_i.a_valid && !a_ready) |=> (bus.tl_i.a_valid && $stable(a_fields)));

  count_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= DEPTH);

  stray_rvalid_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.rvalid_i |-> mem_hit);

endmodule

// File: tb/tb_tluh_mem_responder.sv
// Directed bench for tluh_mem_responder: a vector table of single transactions
// plus scripted multi-cycle sequences for back-pressure, ordering and reset.
module tb_tluh_mem_responder;
  import tluh_32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  tluh_mem_responder_if bus ();

  tluh_mem_responder #(.Outstanding(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rerr;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wmask;
    logic [2:0]  exp_dop;
    logic [31:0] exp_ddata;
    logic        exp_derr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_a(input logic valid, input logic [2:0] op, input logic [2:0] param,
                         input logic [1:0] size, input logic [7:0] src, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
    bus.tl_i.a_valid   = valid;
    bus.tl_i.a_opcode  = tl_a_op_e'(op);
    bus.tl_i.a_param   = param;
    bus.tl_i.a_size    = size;
    bus.tl_i.a_source  = src;
    bus.tl_i.a_address = addr;
    bus.tl_i.a_mask    = mask;
    bus.tl_i.a_data    = data;
    bus.tl_i.a_user    = 16'h5a5a;
  endtask

  task automatic drive_get(input logic [7:0] src, input logic [31:0] addr);
    drive_a(1'b1, 3'h4, 3'h0, 2'd2, src, addr, 4'hF, 32'h0);
  endtask

  task automatic idle_a();
    drive_a(1'b0, 3'h4, 3'h0, 2'd2, 8'h0, 32'h0, 4'hF, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        op    prm   sz    src    addr   mask  wdata         rdata         rerr req we exp_addr exp_wmask     dop   ddata         derr
    vecs[0]  = '{3'h4, 3'h0, 2'd2, 8'd3,  32'h10, 4'hF, 32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h10, 32'hFFFFFFFF, 3'h1, 32'hDEADBEEF, 0};
    vecs[1]  = '{3'h1, 3'h0, 2'd1, 8'd5,  32'h22, 4'hC, 32'hABCD0000, 32'h12345678, 0, 1, 1, 32'h20, 32'hFFFF0000, 3'h0, 32'h0,        0};
    vecs[2]  = '{3'h4, 3'h0, 2'd2, 8'd7,  32'h01, 4'hF, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h1, 32'h0,        1};
    vecs[3]  = '{3'h0, 3'h0, 2'd2, 8'd1,  32'h04, 4'hF, 32'h11223344, 32'h00000055, 1, 1, 1, 32'h04, 32'hFFFFFFFF, 3'h0, 32'h0,        1};
    vecs[4]  = '{3'h0, 3'h0, 2'd2, 8'd8,  32'h08, 4'h7, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h0, 32'h0,        1};
    vecs[5]  = '{3'h4, 3'h0, 2'd0, 8'd2,  32'h13, 4'h8, 32'h0,        32'hA5000000, 1, 1, 0, 32'h10, 32'hFF000000, 3'h1, 32'hA5000000, 1};
    vecs[6]  = '{3'h3, 3'h0, 2'd2, 8'd11, 32'h00, 4'hF, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h0, 32'h0,        1};
    vecs[7]  = '{3'h4, 3'h1, 2'd2, 8'd12, 32'h00, 4'hF, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h1, 32'h0,        1};
    vecs[8]  = '{3'h4, 3'h0, 2'd3, 8'd13, 32'h00, 4'hF, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h1, 32'h0,        1};
    vecs[9]  = '{3'h4, 3'h0, 2'd1, 8'd9,  32'h20, 4'h7, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h1, 32'h0,        1};
    vecs[10] = '{3'h4, 3'h0, 2'd1, 8'd10, 32'h32, 4'h4, 32'h0,        32'hCAFEF00D, 0, 1, 0, 32'h30, 32'h00FF0000, 3'h1, 32'hCAFEF00D, 0};
    vecs[11] = '{3'h1, 3'h0, 2'd0, 8'd14, 32'h41, 4'h1, 32'h0,        32'h0,        0, 0, 0, 32'h0,  32'h0,        3'h0, 32'h0,        1};

    rst              = 1'b1;
    bus.gnt_i        = 1'b1;
    bus.rvalid_i     = 1'b0;
    bus.rdata_i      = '0;
    bus.rerror_i     = 1'b0;
    bus.tl_i.d_ready = 1'b1;
    drive_get(8'd1, 32'h0);

    // Reset state with a legal request already presented.
    @(negedge clk); #1;
    chk("rst_d_valid", 32'(bus.tl_o.d_valid), 32'd0);
    chk("rst_a_ready", 32'(bus.tl_o.a_ready), 32'd0);
    chk("rst_req",     32'(bus.req_o),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_a();

    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive_a(1'b1, vecs[v].op, vecs[v].param, vecs[v].size, vecs[v].src, vecs[v].addr,
              vecs[v].mask, vecs[v].wdata);
      #1;
      chk($sformatf("v%0d_req", v),     32'(bus.req_o),        32'(vecs[v].exp_req));
      chk($sformatf("v%0d_a_ready", v), 32'(bus.tl_o.a_ready), 32'd1);
      if (vecs[v].exp_req) begin
        chk($sformatf("v%0d_we", v),    32'(bus.we_o), 32'(vecs[v].exp_we));
        chk($sformatf("v%0d_addr", v),  bus.addr_o,    vecs[v].exp_addr);
        chk($sformatf("v%0d_wmask", v), bus.wmask_o,   vecs[v].exp_wmask);
        if (vecs[v].exp_we) chk($sformatf("v%0d_wdata", v), bus.wdata_o, vecs[v].wdata);
      end
      @(negedge clk);
      idle_a();
      if (vecs[v].exp_req) begin
        #1;
        chk($sformatf("v%0d_d_early", v), 32'(bus.tl_o.d_valid), 32'd0);
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = vecs[v].rdata;
        bus.rerror_i = vecs[v].rerr;
        @(negedge clk);
        bus.rvalid_i = 1'b0;
        bus.rdata_i  = '0;
        bus.rerror_i = 1'b0;
      end
      #1;
      chk($sformatf("v%0d_d_valid", v), 32'(bus.tl_o.d_valid),  32'd1);
      chk($sformatf("v%0d_d_op", v),    32'(bus.tl_o.d_opcode), 32'(vecs[v].exp_dop));
      chk($sformatf("v%0d_d_data", v),  bus.tl_o.d_data,        vecs[v].exp_ddata);
      chk($sformatf("v%0d_d_err", v),   32'(bus.tl_o.d_error),  32'(vecs[v].exp_derr));
      chk($sformatf("v%0d_d_src", v),   32'(bus.tl_o.d_source), 32'(vecs[v].src));
      chk($sformatf("v%0d_d_size", v),  32'(bus.tl_o.d_size),   32'(vecs[v].size));
      @(negedge clk); #1;
      chk($sformatf("v%0d_d_done", v),  32'(bus.tl_o.d_valid),  32'd0);
    end

    // Back-pressure: two entries fill the FIFO, the third Get waits for a pop.
    bus.tl_i.d_ready = 1'b0;
    @(negedge clk);
    drive_get(8'd1, 32'h100); #1;
    chk("bp_a1_ready", 32'(bus.tl_o.a_ready), 32'd1);
    @(negedge clk);
    drive_get(8'd2, 32'h104); #1;
    chk("bp_a2_ready", 32'(bus.tl_o.a_ready), 32'd1);
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'h100;
    @(negedge clk);
    drive_get(8'd3, 32'h108);
    bus.rdata_i = 32'h200; #1;
    chk("bp_full_ready", 32'(bus.tl_o.a_ready), 32'd0);
    chk("bp_full_req",   32'(bus.req_o),        32'd0);
    @(negedge clk);
    bus.rvalid_i = 1'b0; #1;
    chk("bp_d1_valid", 32'(bus.tl_o.d_valid),  32'd1);
    chk("bp_d1_src",   32'(bus.tl_o.d_source), 32'd1);
    chk("bp_d1_data",  bus.tl_o.d_data,        32'h100);
    @(negedge clk); #1;
    chk("bp_d1_hold",  32'(bus.tl_o.d_source), 32'd1);
    bus.tl_i.d_ready = 1'b1; #1;
    chk("bp_pop_full_ready", 32'(bus.tl_o.a_ready), 32'd0);
    @(negedge clk); #1;
    chk("bp_a3_ready", 32'(bus.tl_o.a_ready),  32'd1);
    chk("bp_d2_src",   32'(bus.tl_o.d_source), 32'd2);
    chk("bp_d2_data",  bus.tl_o.d_data,        32'h200);
    @(negedge clk);
    idle_a(); #1;
    chk("bp_d3_pend", 32'(bus.tl_o.d_valid), 32'd0);
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'h300;
    @(negedge clk);
    bus.rvalid_i = 1'b0; #1;
    chk("bp_d3_src",  32'(bus.tl_o.d_source), 32'd3);
    chk("bp_d3_data", bus.tl_o.d_data,        32'h300);
    @(negedge clk); #1;
    chk("bp_empty", 32'(bus.tl_o.d_valid), 32'd0);

    // Ordering: an error entry must wait behind an older pending Get.
    @(negedge clk);
    drive_get(8'd4, 32'h200); #1;
    chk("ord_a4_ready", 32'(bus.tl_o.a_ready), 32'd1);
    @(negedge clk);
    drive_a(1'b1, 3'h0, 3'h0, 2'd2, 8'd5, 32'h201, 4'hF, 32'h0); #1;
    chk("ord_err_ready", 32'(bus.tl_o.a_ready), 32'd1);
    chk("ord_err_req",   32'(bus.req_o),        32'd0);
    @(negedge clk);
    drive_get(8'd6, 32'h204); #1;
    chk("ord_a6_blocked", 32'(bus.tl_o.a_ready), 32'd0);
    chk("ord_err_held",   32'(bus.tl_o.d_valid), 32'd0);
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'hAAAA0001;
    @(negedge clk);
    bus.rvalid_i = 1'b0; #1;
    chk("ord_d4_src",  32'(bus.tl_o.d_source), 32'd4);
    chk("ord_d4_data", bus.tl_o.d_data,        32'hAAAA0001);
    chk("ord_d4_err",  32'(bus.tl_o.d_error),  32'd0);
    @(negedge clk); #1;
    chk("ord_d5_src",  32'(bus.tl_o.d_source), 32'd5);
    chk("ord_d5_err",  32'(bus.tl_o.d_error),  32'd1);
    chk("ord_d5_op",   32'(bus.tl_o.d_opcode), 32'(AccessAck));
    chk("ord_a6_ready", 32'(bus.tl_o.a_ready), 32'd1);
    @(negedge clk);
    idle_a(); #1;
    chk("ord_d6_pend", 32'(bus.tl_o.d_valid), 32'd0);
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'hBBBB0002;
    @(negedge clk);
    bus.rvalid_i = 1'b0; #1;
    chk("ord_d6_src",  32'(bus.tl_o.d_source), 32'd6);
    chk("ord_d6_data", bus.tl_o.d_data,        32'hBBBB0002);
    @(negedge clk); #1;
    chk("ord_empty", 32'(bus.tl_o.d_valid), 32'd0);

    // Reset with two Gets outstanding; the late memory response is discarded.
    bus.tl_i.d_ready = 1'b0;
    @(negedge clk);
    drive_get(8'd20, 32'h300); #1;
    chk("rs_a20_ready", 32'(bus.tl_o.a_ready), 32'd1);
    @(negedge clk);
    drive_get(8'd21, 32'h304); #1;
    chk("rs_a21_ready", 32'(bus.tl_o.a_ready), 32'd1);
    @(negedge clk);
    idle_a();
    rst = 1'b1; #1;
    chk("rs_d_in_reset", 32'(bus.tl_o.d_valid), 32'd0);
    @(negedge clk);
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    rst = 1'b0;
    bus.rvalid_i = 1'b0; bus.rdata_i = '0; #1;
    chk("rs_d_after", 32'(bus.tl_o.d_valid), 32'd0);
    @(negedge clk); #1;
    chk("rs_d_after2", 32'(bus.tl_o.d_valid), 32'd0);
    @(negedge clk);
    drive_get(8'd22, 32'h310); #1;
    chk("rs_count_clear", 32'(bus.tl_o.a_ready), 32'd1);
    @(negedge clk);
    idle_a(); #1;
    chk("rs_d22_pend", 32'(bus.tl_o.d_valid), 32'd0);
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'h00000077;
    @(negedge clk);
    bus.rvalid_i = 1'b0;
    bus.tl_i.d_ready = 1'b1; #1;
    chk("rs_d22_valid", 32'(bus.tl_o.d_valid),  32'd1);
    chk("rs_d22_src",   32'(bus.tl_o.d_source), 32'd22);
    chk("rs_d22_data",  bus.tl_o.d_data,        32'h77);
    @(negedge clk); #1;
    chk("rs_empty", 32'(bus.tl_o.d_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
